// File: rtl/wb_port_scheduler_if.sv
// Signal bundle between the execute/memory stages, the long-latency unit and the
// register-file write port, as seen by the write-back port scheduler.
interface wb_port_scheduler_if #(
    parameter int width = 32
) ();
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [1:0]       WBSel;
    logic [31:0]      alu_out;
    logic [31:0]      dataR;
    logic [width-1:0] count;
    logic             lu_valid;
    logic [4:0]       lu_rd;
    logic [31:0]      lu_data;
    logic             lu_ready;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             stall;

    modport master (
        output wb_valid, wb_rd, WBSel, alu_out, dataR, count,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, stall
    );

    modport slave (
        input  wb_valid, wb_rd, WBSel, alu_out, dataR, count,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready, rf_we, rf_waddr, rf_wdata, stall
    );
endinterface

// File: rtl/wb_port_scheduler.sv
// Shares the single register-file write port between the core write-back path and a
// queued long-latency unit; core wins, queued results drain in idle slots or on a forced stall.
module wb_port_scheduler #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int width    = 32
) (
    input logic                clk,
    input logic                rst,
    wb_port_scheduler_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    logic [4:0]       mem_rd_q   [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       age_q, age_d;
    state_t           state_q, state_d;

    logic [31:0]      count_ext;
    logic [31:0]      core_wdata;
    logic [DEPTH-1:0] occupied;
    logic             non_empty, full, head_kill, drainable;
    logic             stall_int, core_live, pop, accept, store;
    logic             we_c;
    logic [4:0]       waddr_c;
    logic [31:0]      wdata_c;

    generate
        if (width >= 32) begin : g_cnt_trunc
            assign count_ext = bus.count[31:0];
        end else begin : g_cnt_zext
            assign count_ext = {{(32 - width){1'b0}}, bus.count};
        end
    endgenerate

    always_comb begin
        non_empty = (cnt_q != '0);
        full      = (cnt_q == CNT_W'(DEPTH));
        head_kill = kill_q[rd_ptr_q];
        drainable = non_empty && !head_kill;
        stall_int = (state_q == WAIT) && (age_q == 4'(MAX_WAIT));
        // A forced stall takes the port away from the core for exactly this cycle.
        core_live = bus.wb_valid && (bus.WBSel != 2'b11) && (bus.wb_rd != 5'd0) && !stall_int;
        pop       = !core_live && non_empty;
        accept    = bus.lu_valid && !full && !rst;
        store     = accept && (bus.lu_rd != 5'd0);
    end

    always_comb begin
        case (bus.WBSel)
            2'b00:   core_wdata = bus.dataR;
            2'b01:   core_wdata = bus.alu_out;
            2'b10:   core_wdata = count_ext;
            default: core_wdata = 32'd0;
        endcase
    end

    always_comb begin
        we_c    = 1'b0;
        waddr_c = 5'd0;
        wdata_c = 32'd0;
        if (!rst) begin
            if (core_live) begin
                we_c    = 1'b1;
                waddr_c = bus.wb_rd;
                wdata_c = core_wdata;
            end else if (drainable) begin
                we_c    = 1'b1;
                waddr_c = mem_rd_q[rd_ptr_q];
                wdata_c = mem_data_q[rd_ptr_q];
            end
        end
    end

    assign bus.rf_we    = we_c;
    assign bus.rf_waddr = waddr_c;
    assign bus.rf_wdata = wdata_c;
    assign bus.stall    = stall_int && !rst;
    assign bus.lu_ready = !full && !rst;

    always_comb begin
        logic [PTR_W-1:0] offs;
        offs     = '0;
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs        = PTR_W'(i) - rd_ptr_q;
            occupied[i] = ({1'b0, offs} < cnt_q);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(store);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(store) - CNT_W'(pop);
        kill_d   = kill_q;
        // The younger core write supersedes any queued result to the same register.
        for (int i = 0; i < DEPTH; i++) begin
            if (core_live && occupied[i] && (mem_rd_q[i] == bus.wb_rd)) begin
                kill_d[i] = 1'b1;
            end
        end
        if (store) begin
            kill_d[wr_ptr_q] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        case (state_q)
            IDLE: begin
                if (drainable) begin
                    state_d = WAIT;
                    age_d   = 4'd0;
                end
            end
            WAIT: begin
                if (!non_empty) begin
                    state_d = IDLE;
                    age_d   = 4'd0;
                end else if (pop) begin
                    age_d = 4'd0;
                end else begin
                    age_d = age_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                age_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            age_q    <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            kill_q   <= '0;
        end else begin
            state_q  <= state_d;
            age_q    <= age_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            kill_q   <= kill_d;
        end
    end

    // Payload storage carries no reset; occupancy and kill bits decide what is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_rd_q[wr_ptr_q]   <= bus.lu_rd;
            mem_data_q[wr_ptr_q] <= bus.lu_data;
        end
    end
endmodule

// File: doc/wb_port_scheduler.md
# wb_port_scheduler

Write-back port scheduler for the RISC-V core: shares the single register-file write port between the in-order core write-back path (ALU / load / link value) and a variable-latency unit (multiply/divide or slow memory). Core write-backs have priority. Long-latency results queue in a small FIFO and drain on idle port cycles. A starvation timer stalls the core for one cycle when a queued result has waited too long. The block sits between the execute/memory stage outputs and the register file write port, and drives the core stall line.

## Interface
- `DEPTH`, 2: long-latency result FIFO entries; power of two, ≥ 2.
- `MAX_WAIT`, 4: cycles a FIFO head may wait before a forced stall; range 1–15.
- `width`, 32: width of the `count` (link/PC+4) write-back source.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `wb_valid` in 1: the core instruction in write-back writes a register this cycle.
- `wb_rd` in 5: destination register of the core write-back.
- `WBSel` in 2: source select. 00 = `dataR`, 01 = `alu_out`, 10 = `count`, 11 = no write.
- `alu_out` in 32: ALU result.
- `dataR` in 32: load data.
- `count` in width: link value, zero-extended or truncated to 32 bits.
- `lu_valid` in 1: long-latency unit offers a result.
- `lu_rd` in 5: destination register of the long-latency result.
- `lu_data` in 32: long-latency result data.
- `lu_ready` out 1: FIFO accepts the offered result this cycle.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `stall` out 1: core must hold its current instruction this cycle.

## Operation
- Core request is live when `wb_valid` = 1, `WBSel` ≠ 11, `wb_rd` ≠ 0, and `stall` = 0.
- FIFO head is drainable when the FIFO is non-empty and the head entry is not killed.
- Port grant, evaluated combinationally each cycle:
  - If the core request is live, drive `rf_we` = 1, `rf_waddr` = `wb_rd`, and `rf_wdata` = the `WBSel`-selected source. The FIFO does not pop.
  - Else, if the head is drainable, drive `rf_we` = 1, `rf_waddr`/`rf_wdata` = the head entry, and pop it.
  - Else, if the head is killed, pop it silently with `rf_we` = 0.
  - Otherwise `rf_we` = 0, and `rf_waddr`/`rf_wdata` = 0.
- At most one pop per cycle.
- Push: when `lu_valid` = 1 and `lu_ready` = 1, write {`lu_rd`, `lu_data`, kill = 0} at the tail. A result with `lu_rd` = 0 is accepted and discarded (not stored).
- `lu_ready` = 1 when the FIFO is not full, based on registered occupancy. A pop in the same cycle does not raise `lu_ready`.
- Kill rule: a live core write to rd sets the kill bit on every stored entry with matching rd in that cycle. This applies to entries already stored, not to an entry being pushed that same cycle. The core write is younger and wins.
- Starvation FSM, states IDLE and WAIT:
  - IDLE → WAIT when the FIFO becomes non-empty with a drainable head.
  - In WAIT, the age counter increments each cycle the head is not popped, and clears on every pop.
  - WAIT → IDLE when the FIFO empties.
  - `stall` = 1 when in WAIT and age = `MAX_WAIT`. During that cycle the core request is suppressed and the head drains.
- Simultaneous push and pop: occupancy is unchanged; pointers wrap modulo `DEPTH`.

## Timing
- `rf_we`, `rf_waddr`, `rf_wdata`, and `stall` are combinational from inputs plus registered state. The register file samples them at the next `clk` rising edge. Latency for a core write is 0 cycles.
- A pushed entry is visible at the FIFO head no earlier than the cycle after the push; there is no same-cycle bypass.
- The maximum wait of a drainable head is `MAX_WAIT` cycles, then exactly one stall cycle.
- Reset, asynchronous and immediate:
  - FIFO is emptied and pointers, count, age, and kill bits are cleared; FSM goes to IDLE.
  - While `rst` = 1, outputs are `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `stall` = 0, `lu_ready` = 0.
  - After release, `lu_ready` = 1.
- Reset mid-operation discards queued results with no write.

## Test plan
- **Core path mux:** `wb_valid` = 1, `wb_rd` = 5, `alu_out` = 0x11, `dataR` = 0x22, `count` = 0x33. Sweep `WBSel` = 00/01/10/11 → `rf_wdata` = 0x22/0x11/0x33; for 11, `rf_we` = 0. Also `wb_rd` = 0 → `rf_we` = 0.
- **Idle-slot drain:** push (rd = 7, 0xABCD) with the core idle → next cycle `rf_we` = 1, `rf_waddr` = 7, `rf_wdata` = 0xABCD; FIFO then empty.
- **Full and backpressure:** `DEPTH` = 2, push twice while the core writes every cycle → `lu_ready` = 0 on the third cycle, no entry lost, `stall` = 0 until the age reaches 4.
- **Starvation:** `MAX_WAIT` = 4, continuous core writes with one queued entry → `stall` = 1 in exactly the 5th cycle after the entry reaches the head. The entry is written that cycle and `stall` = 0 the next.
- **Kill:** queue (rd = 9, 0x1), then a core write to rd = 9 with 0x2 → the register file sees only 0x2. The killed entry pops silently, `rf_we` = 0 on that cycle.
- **Reset mid-operation:** two entries queued, assert `rst` asynchronously between clock edges → all outputs are 0 immediately. After release, `lu_ready` = 1 and no stale write occurs.
